// File: rtl/gpu_mem_pkg.sv
// Shared types and constants for the SMCore data-memory arbiter.
package gpu_mem_pkg;

  // Arbiter sequencing: pick a core, run its access, one bubble cycle to finish.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } arb_state_t;

  // Default data-memory widths, matching the widths used by the SMCore datapath.
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_DATA_WIDTH = 32;

  // Width of a requester index; never less than one bit.
  function automatic int clog2_req(input int n);
    int w;
    w = 1;
    for (int k = 1; k < 8; k++) begin
      if ((1 << k) < n) w = k + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/smcore_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_pick
  import gpu_mem_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = clog2_req(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand [N];

  // Candidate gi is the index gi positions after the pointer, wrapped mod N.
  // ptr < N and gi < N, so a single conditional subtract is enough.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_cand
      logic [IDX_W:0] sum;
      logic [IDX_W:0] wrapped;
      assign sum      = {1'b0, ptr} + (IDX_W+1)'(gi);
      assign wrapped  = (sum >= (IDX_W+1)'(N)) ? (sum - (IDX_W+1)'(N)) : sum;
      assign cand[gi] = wrapped[IDX_W-1:0];
    end
  endgenerate

  // Scan from farthest to nearest so the requester closest to the pointer wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        valid = 1'b1;
        idx   = cand[k];
      end
    end
  end

endmodule

// File: rtl/smcore_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between N_REQ SMCores.
// One transaction in flight; all outputs come straight from flops.
module smcore_mem_arbiter
  import gpu_mem_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_read,
  input  logic [N_REQ-1:0]            req_write,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [N_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]       req_rdata,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic [ADDR_WIDTH-1:0]       mem_addr,
  output logic [DATA_WIDTH-1:0]       mem_wdata,
  input  logic [DATA_WIDTH-1:0]       mem_rdata,
  input  logic                        mem_ready,
  output logic [$clog2(N_REQ)-1:0]    grant_id,
  output logic                        busy
);

  localparam int               IDX_W    = clog2_req(N_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  arb_state_t             state_q, state_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]       grant_q, grant_d;
  logic                   mem_read_q, mem_read_d;
  logic                   mem_write_q, mem_write_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0]  req_rdata_q, req_rdata_d;
  logic [N_REQ-1:0]       req_ready_q, req_ready_d;
  logic                   busy_q, busy_d;

  logic [N_REQ-1:0]       req_any;
  logic                   pick_valid;
  logic [IDX_W-1:0]       pick_idx;

  assign req_any = req_read | req_write;

  rr_pick #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req   (req_any),
    .ptr   (rr_ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Next-state and registered-output logic for IDLE -> ISSUE -> DONE.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    req_rdata_d = req_rdata_q;
    req_ready_d = '0;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d     = ISSUE;
          grant_d     = pick_idx;
          mem_addr_d  = req_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
          mem_wdata_d = req_wdata[pick_idx*DATA_WIDTH +: DATA_WIDTH];
          // A core raising both strobes gets a write; the read is dropped.
          mem_write_d = req_write[pick_idx];
          mem_read_d  = req_read[pick_idx] & ~req_write[pick_idx];
        end
      end
      ISSUE: begin
        // Strobes, address and data stay frozen until memory answers.
        if (mem_ready) begin
          mem_read_d           = 1'b0;
          mem_write_d          = 1'b0;
          if (mem_read_q) req_rdata_d = mem_rdata;
          req_ready_d[grant_q] = 1'b1;
          state_d              = DONE;
        end
      end
      DONE: begin
        // Bubble cycle lets the served core drop its request before re-arbitration.
        rr_ptr_d = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      req_rdata_q <= '0;
      req_ready_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      req_rdata_q <= req_rdata_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready = req_ready_q;
  assign req_rdata = req_rdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign grant_id  = grant_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_smcore_mem_arbiter.sv
// Scoreboard bench for smcore_mem_arbiter: directed vectors push expected
// ready/strobe records; independent monitors pop and compare.
module tb_smcore_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_read, req_write, req_ready;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   req_rdata, mem_wdata, mem_rdata;
  logic            mem_read, mem_write, mem_ready, busy;
  logic [AW-1:0]   mem_addr;
  logic [1:0]      grant_id;

  smcore_mem_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_read  (req_read),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .req_rdata (req_rdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  mask;
    logic [DW-1:0] rdata;
    int            id;
  } rsp_t;

  typedef struct {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_t;

  rsp_t rsp_q[$];
  mem_t mem_q[$];

  int n_vec = 0;
  int n_mis = 0;

  int          mem_delay   = 0;
  logic        force_ready = 1'b0;
  logic        rd_fixed_en = 1'b0;
  logic [31:0] rd_fixed    = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int c, input logic rd, input logic wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_read[c]            = rd;
    req_write[c]           = wr;
    req_addr[c*AW +: AW]   = a;
    req_wdata[c*DW +: DW]  = d;
  endtask

  task automatic push_rsp(input int c, input logic [DW-1:0] rdata);
    rsp_t e;
    e.mask  = N'(1 << c);
    e.rdata = rdata;
    e.id    = c;
    rsp_q.push_back(e);
  endtask

  task automatic push_mem(input logic rd, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    mem_t m;
    m.rd = rd; m.wr = wr; m.addr = a; m.wdata = d;
    mem_q.push_back(m);
  endtask

  task automatic wait_ready(input int c);
    int waited;
    waited = 0;
    while (!req_ready[c] && waited < 200) begin
      tick();
      waited++;
    end
    if (!req_ready[c]) chk("ready_timeout", 32'(req_ready[c]), 32'd1);
  endtask

  // Memory model: answers after mem_delay strobe cycles; read data tracks address.
  initial begin : responder
    int cnt;
    cnt = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (force_ready) begin
        mem_ready = 1'b1;
      end else if (mem_read || mem_write) begin
        mem_ready = (cnt >= mem_delay);
        cnt++;
      end else begin
        mem_ready = 1'b0;
        cnt = 0;
      end
      mem_rdata = rd_fixed_en ? rd_fixed : {16'hC0DE, mem_addr};
    end
  end

  // Core-side monitor: every ready pulse must match the next expected response.
  initial begin : rsp_monitor
    rsp_t e;
    forever begin
      @(negedge clk);
      if (req_ready != '0) begin
        if (rsp_q.size() == 0) begin
          chk("spurious_ready", 32'(req_ready), 32'd0);
        end else begin
          e = rsp_q.pop_front();
          $display("txn ready mask=%b grant_id=%0d rdata=%h", req_ready, grant_id, req_rdata);
          chk("ready_mask", 32'(req_ready), 32'(e.mask));
          chk("ready_rdata", req_rdata, e.rdata);
          chk("ready_grant_id", 32'(grant_id), 32'(e.id));
        end
      end
    end
  end

  // Memory-side monitor: new strobes must match expectation and stay stable.
  initial begin : mem_monitor
    mem_t m;
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if ((mem_read || mem_write) && !prev) begin
        if (mem_q.size() == 0) begin
          chk("spurious_strobe", {30'd0, mem_write, mem_read}, 32'd0);
        end else begin
          m = mem_q.pop_front();
          $display("txn strobe rd=%0d wr=%0d addr=%h wdata=%h", mem_read, mem_write, mem_addr, mem_wdata);
          chk("mem_read", 32'(mem_read), 32'(m.rd));
          chk("mem_write", 32'(mem_write), 32'(m.wr));
          chk("mem_addr", 32'(mem_addr), 32'(m.addr));
          chk("mem_wdata", mem_wdata, m.wdata);
        end
      end else if ((mem_read || mem_write) && prev) begin
        chk("hold_read", 32'(mem_read), 32'(m.rd));
        chk("hold_write", 32'(mem_write), 32'(m.wr));
        chk("hold_addr", 32'(mem_addr), 32'(m.addr));
        chk("hold_wdata", mem_wdata, m.wdata);
      end
      prev = mem_read || mem_write;
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: run exceeded time limit, %0d miscompares so far", n_mis);
    $fatal(1, "watchdog expired");
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_req_rdata"}, req_rdata, 32'd0);
    chk({tag, "_mem_read"}, 32'(mem_read), 32'd0);
    chk({tag, "_mem_write"}, 32'(mem_write), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_grant_id"}, 32'(grant_id), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin : stimulus
    int cyc, last_cyc, n_ready, got_core, strobe_cycles, mr_at, ready_at;
    logic reraise;

    reset     = 1'b0;
    req_read  = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;

    // Reset state.
    tick(); tick();
    chk_all_zero("reset");
    reset = 1'b1;
    tick();
    chk("post_reset_busy", 32'(busy), 32'd0);

    // Core 2 read of 0x0040, memory answers on the first strobe cycle.
    rd_fixed_en = 1'b1;
    rd_fixed    = 32'hDEADBEEF;
    set_req(2, 1'b1, 1'b0, 16'h0040, 32'h0);
    push_rsp(2, 32'hDEADBEEF);
    push_mem(1'b1, 1'b0, 16'h0040, 32'h0);
    tick();
    chk("t1_strobe_read", 32'(mem_read), 32'd1);
    chk("t1_strobe_addr", 32'(mem_addr), 32'h0040);
    chk("t1_busy_issue", 32'(busy), 32'd1);
    tick();
    chk("t1_ready_latency", 32'(req_ready), 32'b0100);
    chk("t1_rdata", req_rdata, 32'hDEADBEEF);
    req_read[2] = 1'b0;
    tick();
    chk("t1_busy_low", 32'(busy), 32'd0);
    chk("t1_ready_gone", 32'(req_ready), 32'd0);
    rd_fixed_en = 1'b0;

    // Pointer now at 3: cores 0 and 2 requesting -> 0 served first, then 2.
    set_req(0, 1'b1, 1'b0, 16'h0050, 32'h0);
    set_req(2, 1'b1, 1'b0, 16'h0060, 32'h0);
    push_rsp(0, 32'hC0DE0050);
    push_mem(1'b1, 1'b0, 16'h0050, 32'h0);
    push_rsp(2, 32'hC0DE0060);
    push_mem(1'b1, 1'b0, 16'h0060, 32'h0);
    wait_ready(0);
    req_read[0] = 1'b0;
    wait_ready(2);
    req_read[2] = 1'b0;
    tick();

    // Core 1 write, memory stalls 5 cycles; read data register must not change.
    mem_delay = 5;
    set_req(1, 1'b0, 1'b1, 16'h0010, 32'h12345678);
    push_rsp(1, 32'hC0DE0060);
    push_mem(1'b0, 1'b1, 16'h0010, 32'h12345678);
    strobe_cycles = 0; mr_at = -1; ready_at = -1; cyc = 0;
    while (ready_at < 0 && cyc < 100) begin
      tick();
      cyc++;
      if (req_ready[1]) ready_at = cyc;
      if (mem_write) strobe_cycles++;
      if (mem_ready && mr_at < 0) mr_at = cyc;
    end
    chk("t2_strobe_cycles", 32'(strobe_cycles), 32'd6);
    chk("t2_ready_after_mem_ready", 32'(ready_at - mr_at), 32'd1);
    req_write[1] = 1'b0;
    mem_delay = 0;
    tick();
    chk("t2_single_pulse", 32'(req_ready), 32'd0);

    // Reset in the middle of an ISSUE read: outputs clear at once, no ready later.
    mem_delay = 1000;
    set_req(0, 1'b1, 1'b0, 16'h0070, 32'h0);
    push_mem(1'b1, 1'b0, 16'h0070, 32'h0);
    cyc = 0;
    while (!mem_read && cyc < 20) begin
      tick();
      cyc++;
    end
    chk("rst_in_issue", 32'(mem_read), 32'd1);
    tick();
    reset = 1'b0;
    #1;
    chk_all_zero("async_reset");
    req_read[0] = 1'b0;
    mem_delay = 0;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("rst_release_busy", 32'(busy), 32'd0);
    chk("rst_release_strobe", {30'd0, mem_write, mem_read}, 32'd0);

    // All four cores request; core 0 re-requests after its first service.
    for (int c = 0; c < N; c++) begin
      set_req(c, 1'b1, 1'b0, 16'(16'h0100 + c), 32'h0);
      push_rsp(c, {16'hC0DE, 16'(16'h0100 + c)});
      push_mem(1'b1, 1'b0, 16'(16'h0100 + c), 32'h0);
    end
    n_ready = 0; last_cyc = 0; cyc = 0; reraise = 1'b0; got_core = -1;
    while (n_ready < 5 && cyc < 100) begin
      tick();
      cyc++;
      if (reraise) begin
        set_req(0, 1'b1, 1'b0, 16'h0200, 32'h0);
        push_rsp(0, 32'hC0DE0200);
        push_mem(1'b1, 1'b0, 16'h0200, 32'h0);
        reraise = 1'b0;
      end
      if (req_ready != '0) begin
        for (int c = 0; c < N; c++) begin
          if (req_ready[c]) begin
            req_read[c] = 1'b0;
            got_core = c;
          end
        end
        if (n_ready > 0) chk("fair_spacing", 32'(cyc - last_cyc), 32'd3);
        if (n_ready == 0 && got_core == 0) reraise = 1'b1;
        last_cyc = cyc;
        n_ready++;
      end
    end
    chk("fair_grants", 32'(n_ready), 32'd5);
    tick();

    // Core 0 raises read and write together: the write wins.
    set_req(0, 1'b1, 1'b1, 16'h0020, 32'hCAFEF00D);
    push_rsp(0, 32'hC0DE0200);
    push_mem(1'b0, 1'b1, 16'h0020, 32'hCAFEF00D);
    wait_ready(0);
    req_read[0]  = 1'b0;
    req_write[0] = 1'b0;
    tick();

    // Core 3 withdraws and scribbles its address mid-ISSUE; access still completes.
    mem_delay = 3;
    set_req(3, 1'b1, 1'b0, 16'h0030, 32'h0);
    push_rsp(3, 32'hC0DE0030);
    push_mem(1'b1, 1'b0, 16'h0030, 32'h0);
    cyc = 0;
    while (!mem_read && cyc < 20) begin
      tick();
      cyc++;
    end
    set_req(3, 1'b0, 1'b0, 16'hFFFF, 32'hFFFFFFFF);
    wait_ready(3);
    mem_delay = 0;
    tick();

    // mem_ready while idle must be ignored.
    force_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("idle_ready_busy", 32'(busy), 32'd0);
    end
    force_ready = 1'b0;
    tick(); tick();

    chk("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
    chk("mem_queue_drained", 32'(mem_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
